// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: free-running VGA raster timing (640x480 @ 60 Hz by default) from a 50 MHz clock.
// Latency: hSync/vSync/bright are registered from the next counter values, so they always line up
//          with the hCount/vCount currently on the outputs; frameTick is decoded combinationally.
// Backpressure: none. The block free-runs, and only rst alters the sequence.
//
// Ports:
//   clk        system clock (50 MHz)
//   rst        synchronous, active-high reset
//   pixEn      pixel-rate enable, toggles every clk (25 MHz, 50% duty)
//   hCount     horizontal position, 0 .. H_TOTAL-1
//   vCount     vertical position, 0 .. V_TOTAL-1
//   hSync      horizontal sync, active low
//   vSync      vertical sync, active low
//   bright     high inside the visible region
//   frameTick  one-clk end-of-frame strobe; present only when VGA_FRAME_TICK_EN is defined
//
// Optional feature macro: VGA_FRAME_TICK_EN (adds the frameTick output).
//
// The count origin is the leading edge of sync, so each axis runs:
// sync, back porch, active, front porch.

module vga_timing_ctrl #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pixEn,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic       frameTick
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0] H_VIS_BEG = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_VIS_END = 10'(H_SYNC + H_BACK + H_ACTIVE);  // exclusive
  localparam logic [9:0] V_VIS_BEG = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_VIS_END = 10'(V_SYNC + V_BACK + V_ACTIVE);  // exclusive

  logic [9:0] h_next;
  logic [9:0] v_next;

  // Next raster position. The counters only move on edges where pixEn is already high,
  // so each position holds for exactly two clk.
  always_comb begin
    h_next = hCount;
    v_next = vCount;
    if (pixEn) begin
      if (hCount == H_LAST) begin
        h_next = 10'd0;
        v_next = (vCount == V_LAST) ? 10'd0 : vCount + 10'd1;
      end else begin
        h_next = hCount + 10'd1;
      end
    end
  end

  // The sync and bright flags are decoded from the next position and registered alongside
  // the counters, so they never lag the coordinates by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixEn  <= 1'b0;
      hCount <= 10'd0;
      vCount <= 10'd0;
      hSync  <= 1'b0;
      vSync  <= 1'b0;
      bright <= 1'b0;
    end else begin
      pixEn  <= ~pixEn;
      hCount <= h_next;
      vCount <= v_next;
      hSync  <= (h_next >= H_SYNC_END);
      vSync  <= (v_next >= V_SYNC_END);
      bright <= (h_next >= H_VIS_BEG) && (h_next < H_VIS_END) &&
                (v_next >= V_VIS_BEG) && (v_next < V_VIS_END);
    end
  end

`ifdef VGA_FRAME_TICK_EN
  // High on the single clk before the counters wrap to (0,0).
  assign frameTick = pixEn && (hCount == H_LAST) && (vCount == V_LAST);
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: checks a default-size raster and a shrunken raster side by side.
// An independent position model pushes the expected output word every clk; a checker pops and compares.
// Directed measurements cover sync widths, periods, bright edges, frameTick and a mid-frame reset.
`timescale 1ns/1ps

module tb_vga_timing_ctrl;

  // Shrunken raster: 17 x 12 positions, 408 clk per frame.
  localparam int SH_S = 4, SH_B = 3, SH_A = 8, SH_F = 2;
  localparam int SV_S = 2, SV_B = 3, SV_A = 5, SV_F = 2;
  localparam int S_HT = SH_S + SH_B + SH_A + SH_F;
  localparam int S_VT = SV_S + SV_B + SV_A + SV_F;

`ifdef VGA_FRAME_TICK_EN
  localparam int FT_EXP = 1;
`else
  localparam int FT_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  logic       d_pix, d_hs, d_vs, d_br, d_ft;
  logic [9:0] d_h, d_v;
  logic       s_pix, s_hs, s_vs, s_br, s_ft;
  logic [9:0] s_h, s_v;

  vga_timing_ctrl dut_d (
    .clk(clk), .rst(rst), .pixEn(d_pix), .hCount(d_h), .vCount(d_v),
    .hSync(d_hs), .vSync(d_vs), .bright(d_br)
`ifdef VGA_FRAME_TICK_EN
    , .frameTick(d_ft)
`endif
  );

  vga_timing_ctrl #(
    .H_SYNC(SH_S), .H_BACK(SH_B), .H_ACTIVE(SH_A), .H_FRONT(SH_F),
    .V_SYNC(SV_S), .V_BACK(SV_B), .V_ACTIVE(SV_A), .V_FRONT(SV_F)
  ) dut_s (
    .clk(clk), .rst(rst), .pixEn(s_pix), .hCount(s_h), .vCount(s_v),
    .hSync(s_hs), .vSync(s_vs), .bright(s_br)
`ifdef VGA_FRAME_TICK_EN
    , .frameTick(s_ft)
`endif
  );

`ifndef VGA_FRAME_TICK_EN
  assign d_ft = 1'b0;
  assign s_ft = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected output word after n edges since reset release (n=0 is the reset state):
  // pixEn toggles each edge, the position advances on every second edge.
  function automatic logic [24:0] model(input int n, input int hs, input int hb, input int ha,
                                        input int hf, input int vs, input int vb, input int va,
                                        input int vf);
    int ht, vt, pos, h, v;
    logic pe, hsy, vsy, br, ft;
    ht  = hs + hb + ha + hf;
    vt  = vs + vb + va + vf;
    pe  = (n % 2) == 1;
    pos = (n / 2) % (ht * vt);
    h   = pos % ht;
    v   = pos / ht;
    hsy = !(h < hs);
    vsy = !(v < vs);
    br  = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < vs + vb + va);
    ft  = (FT_EXP == 1) && pe && (h == ht - 1) && (v == vt - 1);
    return {pe, hsy, vsy, br, ft, h[9:0], v[9:0]};
  endfunction

  // Scoreboard producer: one expected word per DUT per clk edge.
  int   n_edges = 0;
  bit   started = 1'b0;
  logic [24:0] q_d[$];
  logic [24:0] q_s[$];

  always @(posedge clk) begin
    if (rst) begin
      n_edges = 0;
      started = 1'b1;
    end else if (started) begin
      n_edges++;
    end
    if (started) begin
      q_d.push_back(model(n_edges, 96, 48, 640, 16, 2, 33, 480, 10));
      q_s.push_back(model(n_edges, SH_S, SH_B, SH_A, SH_F, SV_S, SV_B, SV_A, SV_F));
    end
  end

  // Scoreboard consumer, sampling on the falling edge.
  always @(negedge clk) begin
    logic [24:0] e;
    if (q_d.size() > 0) begin
      e = q_d.pop_front();
      chk("sb_dflt", {7'd0, d_pix, d_hs, d_vs, d_br, d_ft, d_h, d_v}, {7'd0, e});
    end
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      chk("sb_small", {7'd0, s_pix, s_hs, s_vs, s_br, s_ft, s_h, s_v}, {7'd0, e});
    end
  end

  initial begin
    int hs_low, wraps, cyc, edges, fe1, fe2, vs_low, ft_cnt, br_rises, br_clk;
    logic [9:0] prev_h, prev_v;
    logic pv_vs, pv_br;
    bit found;

    // Reset held for three edges.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dflt", {d_pix, d_hs, d_vs, d_br, d_ft, d_h, d_v}, 32'd0);
    chk("rst_small", {s_pix, s_hs, s_vs, s_br, s_ft, s_h, s_v}, 32'd0);
    rst = 1'b0;

    @(negedge clk);
    chk("rel1_pix", {31'd0, d_pix}, 32'd1);
    chk("rel1_h", {22'd0, d_h}, 32'd0);
    @(negedge clk);
    chk("rel2_h", {22'd0, d_h}, 32'd1);

    // One full default line: hSync low 192 clk, and a single wrap that bumps vCount.
    hs_low = 0;
    wraps  = 0;
    prev_h = d_h;
    prev_v = d_v;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      if (!d_hs) hs_low++;
      if (prev_h == 10'd799 && d_h == 10'd0) begin
        wraps++;
        chk("v_inc", {12'd0, prev_v, d_v}, {12'd0, 10'd0, 10'd1});
      end
      prev_h = d_h;
      prev_v = d_v;
    end
    chk("hs_low_clk", hs_low, 192);
    chk("line_wraps", wraps, 1);

    // One full small frame, delimited by two vSync falling edges.
    edges = 0; cyc = 0; fe1 = 0; fe2 = 0;
    vs_low = 0; ft_cnt = 0; br_rises = 0; br_clk = 0;
    pv_vs = s_vs;
    pv_br = s_br;
    while (edges < 2 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (pv_vs && !s_vs) begin
        edges++;
        if (edges == 1) fe1 = cyc;
        else fe2 = cyc;
      end
      if (edges == 1) begin
        if (!s_vs) vs_low++;
        if (s_ft) ft_cnt++;
        if (s_br) br_clk++;
        if (!pv_br && s_br) begin
          br_rises++;
          chk("br_rise_h", {22'd0, s_h}, SH_S + SH_B);
          if (br_rises == 1) chk("br_rise_v", {22'd0, s_v}, SV_S + SV_B);
        end
        if (pv_br && !s_br) chk("br_fall_h", {22'd0, s_h}, SH_S + SH_B + SH_A);
      end
      pv_vs = s_vs;
      pv_br = s_br;
    end
    chk("vs_edges", edges, 2);
    chk("frame_clk", fe2 - fe1, 2 * S_HT * S_VT);
    chk("vs_low_clk", vs_low, 2 * SV_S * S_HT);
    chk("ft_per_frame", ft_cnt, FT_EXP);
    chk("br_lines", br_rises, SV_A);
    chk("br_clk", br_clk, 2 * SH_A * SV_A);

    // Mid-frame reset for a single edge.
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (s_h == 10'd9 && s_v == 10'd7) found = 1'b1;
    end
    chk("reach_mid", {31'd0, found}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_small", {s_pix, s_hs, s_vs, s_br, s_ft, s_h, s_v}, 32'd0);
    chk("mid_rst_dflt", {d_pix, d_hs, d_vs, d_br, d_ft, d_h, d_v}, 32'd0);
    @(negedge clk);
    chk("restart_pix", {31'd0, s_pix}, 32'd1);
    @(negedge clk);
    chk("restart_h", {12'd0, s_h, s_v}, {12'd0, 10'd1, 10'd0});
    repeat (50) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
